toggle_and_stream: RTL and testbench



---
 rtl/toggle_and_pkg.sv | 13 +
 rtl/toggle_and_stream_if.sv | 32 +++
 rtl/toggle_and_ostage.sv | 30 +++
 rtl/toggle_and_stream.sv | 100 ++++++++++
 tb/tb_toggle_and_stream.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/toggle_and_pkg.sv
// Shared types for the toggle/AND lane stream block.
// Phase tags and the hand-off counter width.
package toggle_and_pkg;

   typedef enum logic [1:0] {
      START = 2'd0,
      EVEN  = 2'd1,
      ODD   = 2'd2
   } tag_t;

   localparam int CNT_W = 16;

endpackage

// File: rtl/toggle_and_stream_if.sv
// Valid/ready stream bundle around toggle_and_stream.
// master = producer/consumer side, slave = the block.
interface toggle_and_stream_if #(
   parameter int WIDTH = 8
);

   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

endinterface

// File: rtl/toggle_and_ostage.sv
// Registered valid/ready output stage; a load replaces
// the held result in the same edge it is handed off.
module toggle_and_ostage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             out_ready,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= d;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/toggle_and_stream.sv
// Lane-wise toggle/AND stream block, 1-cycle latency.
// TOGGLE_AND_STREAM_CNT_EN adds a saturating beat_cnt.
module toggle_and_stream
   import toggle_and_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] INIT_TOG = {WIDTH{1'b1}}
) (
   input  logic clk,
   input  logic rst,
   toggle_and_stream_if.slave s
`ifdef TOGGLE_AND_STREAM_CNT_EN
   ,
   output logic [CNT_W-1:0] beat_cnt
`endif
);

   tag_t             tag_q;
   tag_t             tag_d;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] prev_d;
   logic [WIDTH-1:0] tog_q;
   logic [WIDTH-1:0] tog_d;
   logic [WIDTH-1:0] res;
   logic             load;
   logic             in_ready;
   logic             accept;

   assign s.in_ready = in_ready;
   assign accept     = s.in_valid && in_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_q  <= START;
         prev_q <= '0;
         tog_q  <= INIT_TOG;
      end else begin
         tag_q  <= tag_d;
         prev_q <= prev_d;
         tog_q  <= tog_d;
      end
   end

   always_comb begin
      tag_d  = tag_q;
      prev_d = prev_q;
      tog_d  = tog_q;
      res    = '0;
      load   = 1'b0;
      if (accept) begin
         unique case (tag_q)
            START: begin
               prev_d = s.in_data;
               tog_d  = INIT_TOG;
               tag_d  = EVEN;
            end
            EVEN: begin
               res    = s.in_data & prev_q;
               load   = 1'b1;
               prev_d = s.in_data;
               tog_d  = tog_q ^ s.in_data;
               tag_d  = ODD;
            end
            ODD: begin
               res    = s.in_data & tog_q;
               load   = 1'b1;
               prev_d = s.in_data;
               tag_d  = EVEN;
            end
            // illegal tag: drop the beat and re-prime
            default: tag_d = START;
         endcase
      end
   end

   toggle_and_ostage #(
      .WIDTH(WIDTH)
   ) u_ostage (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .d        (res),
      .out_ready(s.out_ready),
      .in_ready (in_ready),
      .out_valid(s.out_valid),
      .out_data (s.out_data)
   );

`ifdef TOGGLE_AND_STREAM_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_cnt <= '0;
      end else if (s.out_valid && s.out_ready &&
                   beat_cnt != {CNT_W{1'b1}}) begin
         beat_cnt <= beat_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_toggle_and_stream.sv
// Self-checking bench for toggle_and_stream (WIDTH=4).
// Reference model works on beat index since reset.
module tb_toggle_and_stream;
   import toggle_and_pkg::*;

   localparam int         W    = 4;
   localparam logic [3:0] INIT = 4'hF;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   int         m_n;
   logic [3:0] m_prev;
   logic [3:0] m_tog;

   toggle_and_stream_if #(.WIDTH(W)) bus ();

`ifdef TOGGLE_AND_STREAM_CNT_EN
   logic [15:0] beat_cnt;
`endif

   toggle_and_stream #(
      .WIDTH   (W),
      .INIT_TOG(INIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .s  (bus)
`ifdef TOGGLE_AND_STREAM_CNT_EN
      ,
      .beat_cnt(beat_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // beat 0 primes; odd beats AND with the previous beat and
   // fold into the mask; even beats (>=2) AND with the mask
   function automatic logic [W:0] ref_beat(input logic [W-1:0] d);
      logic [W:0] r;
      r = '0;
      if (m_n == 0) begin
         m_tog = INIT;
      end else if (m_n % 2 == 1) begin
         r     = {1'b1, d & m_prev};
         m_tog = m_tog ^ d;
      end else begin
         r = {1'b1, d & m_tog};
      end
      m_prev = d;
      m_n++;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.out_ready = 1'b1;
      repeat (2) tick();
      rst = 1'b1;
      m_n = 0;
      tick();
   endtask

   task automatic test_reset();
      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      #3;
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_ovalid: got %b want 0", bus.out_valid);
      end
      tick();
      rst = 1'b1;
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rel_ovalid: got %b want 0", bus.out_valid);
      end
      n_cmp++;
      if (bus.out_data !== 4'h0) begin
         n_bad++;
         $display("FAIL rel_odata: got %h want 0", bus.out_data);
      end
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rel_iready: got %b want 1", bus.in_ready);
      end
      n_cmp++;
      if (dut.tag_q !== START) begin
         n_bad++;
         $display("FAIL rel_tag: got %0d want 0", dut.tag_q);
      end
   endtask

   task automatic test_basic();
      logic [3:0] bt [4];
      logic [3:0] ex [4];
      bt = '{4'hA, 4'h6, 4'hD, 4'h3};
      ex = '{4'h0, 4'h2, 4'h9, 4'h1};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = bt[i];
         tick();
         n_cmp++;
         if (bus.out_valid !== (i != 0)) begin
            n_bad++;
            $display("FAIL basic_v%0d: got %b want %b",
                     i, bus.out_valid, i != 0);
         end
         if (i != 0) begin
            n_cmp++;
            if (bus.out_data !== ex[i]) begin
               n_bad++;
               $display("FAIL basic_d%0d: got %h want %h",
                        i, bus.out_data, ex[i]);
            end
         end
      end
      bus.in_valid = 1'b0;
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_drain: got %b want 0", bus.out_valid);
      end
      n_cmp++;
      if (dut.tog_q !== 4'hA) begin
         n_bad++;
         $display("FAIL basic_tog: got %h want a", dut.tog_q);
      end
   endtask

   task automatic test_stall();
      do_reset();
      bus.in_valid = 1'b1;
      bus.in_data  = 4'hA;
      tick();
      bus.in_data = 4'h6;
      tick();
      bus.out_ready = 1'b0;
      bus.in_data   = 4'hD;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h2) begin
            n_bad++;
            $display("FAIL stall_hold%0d: got %b/%h want 1/2",
                     i, bus.out_valid, bus.out_data);
         end
         n_cmp++;
         if (bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_rdy%0d: got %b want 0",
                     i, bus.in_ready);
         end
      end
      bus.out_ready = 1'b1;
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h9) begin
         n_bad++;
         $display("FAIL stall_r1: got %b/%h want 1/9",
                  bus.out_valid, bus.out_data);
      end
      bus.in_data = 4'h3;
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h1) begin
         n_bad++;
         $display("FAIL stall_r2: got %b/%h want 1/1",
                  bus.out_valid, bus.out_data);
      end
      bus.in_valid = 1'b0;
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL stall_drain: got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.in_valid = 1'b1;
      bus.in_data  = 4'hA;
      tick();
      bus.in_data = 4'h6;
      tick();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h2) begin
         n_bad++;
         $display("FAIL mid_pend: got %b/%h want 1/2",
                  bus.out_valid, bus.out_data);
      end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0) begin
         n_bad++;
         $display("FAIL mid_async: got %b/%h want 0/0",
                  bus.out_valid, bus.out_data);
      end
      tick();
      rst = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 4'h5;
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_prime: got %b want 0", bus.out_valid);
      end
      bus.in_data = 4'h7;
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h5) begin
         n_bad++;
         $display("FAIL mid_first: got %b/%h want 1/5",
                  bus.out_valid, bus.out_data);
      end
      bus.in_valid = 1'b0;
      tick();
   endtask

   task automatic test_random();
      logic [W:0]   r;
      logic [W-1:0] d;
      do_reset();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         d = W'($urandom);
         bus.in_valid = 1'b1;
         bus.in_data  = d;
         #1;
         n_cmp++;
         if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rnd_rdy%0d: got %b want 1",
                     i, bus.in_ready);
         end
         @(posedge clk);
         #1;
         r = ref_beat(d);
         n_cmp++;
         if (bus.out_valid !== r[W]) begin
            n_bad++;
            $display("FAIL rnd_v%0d: got %b want %b",
                     i, bus.out_valid, r[W]);
         end
         if (r[W]) begin
            n_cmp++;
            if (bus.out_data !== r[W-1:0]) begin
               n_bad++;
               $display("FAIL rnd_d%0d: got %h want %h",
                        i, bus.out_data, r[W-1:0]);
            end
         end
      end
      bus.in_valid = 1'b0;
      tick();
   endtask

   task automatic test_random_stall();
      logic [W:0]   r;
      logic [W-1:0] d;
      logic         ev;
      logic [W-1:0] ed;
      logic         er;
      logic         iv;
      ev = 1'b0;
      ed = '0;
      do_reset();
      for (int i = 0; i < 200; i++) begin
         iv = ($urandom_range(0, 9) < 7);
         d  = W'($urandom);
         bus.in_valid  = iv;
         bus.in_data   = d;
         bus.out_ready = ($urandom_range(0, 9) < 6);
         #1;
         er = !ev || bus.out_ready;
         n_cmp++;
         if (bus.in_ready !== er) begin
            n_bad++;
            $display("FAIL rs_rdy%0d: got %b want %b",
                     i, bus.in_ready, er);
         end
         @(posedge clk);
         #1;
         if (iv && er) begin
            r  = ref_beat(d);
            ev = r[W];
            if (r[W]) ed = r[W-1:0];
         end else if (bus.out_ready) begin
            ev = 1'b0;
         end
         n_cmp++;
         if (bus.out_valid !== ev) begin
            n_bad++;
            $display("FAIL rs_v%0d: got %b want %b",
                     i, bus.out_valid, ev);
         end
         if (ev) begin
            n_cmp++;
            if (bus.out_data !== ed) begin
               n_bad++;
               $display("FAIL rs_d%0d: got %h want %h",
                        i, bus.out_data, ed);
            end
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
   endtask

`ifdef TOGGLE_AND_STREAM_CNT_EN
   task automatic test_cnt();
      do_reset();
      n_cmp++;
      if (beat_cnt !== 16'd0) begin
         n_bad++;
         $display("FAIL cnt_rst: got %0d want 0", beat_cnt);
      end
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_data   = 4'h5;
      repeat (12) tick();
      n_cmp++;
      if (beat_cnt !== 16'd10) begin
         n_bad++;
         $display("FAIL cnt_10: got %0d want 10", beat_cnt);
      end
      repeat (70000) tick();
      n_cmp++;
      if (beat_cnt !== 16'hFFFF) begin
         n_bad++;
         $display("FAIL cnt_sat: got %h want ffff", beat_cnt);
      end
      bus.in_valid = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (beat_cnt !== 16'hFFFF) begin
         n_bad++;
         $display("FAIL cnt_hold: got %h want ffff", beat_cnt);
      end
   endtask
`endif

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      m_n    = 0;
      m_prev = '0;
      m_tog  = INIT;
      test_reset();
      test_basic();
      test_stall();
      test_reset_mid();
      test_random();
      test_random_stall();
`ifdef TOGGLE_AND_STREAM_CNT_EN
      test_cnt();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
